// File: rtl/reg_file.sv
// 31x32 register file with write-first bypass and a per-register pending-write scoreboard.
// Reads and hazard_stall are combinational; counters update one edge after issue/retire/flush.
module reg_file #(
  parameter int PCNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_w_from_wb,
  input  logic [4:0]  wr_back_addr,
  input  logic [31:0] wr_back_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic        issue_valid,
  input  logic        issue_rd_w,
  input  logic [4:0]  issue_rd_addr,
  input  logic        flush,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        hazard_stall
);

  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  logic [31:0]       regs [31:1];
  logic [PCNT_W-1:0] pcnt [31:1];

  logic        wb_en;
  logic        issue_req;
  logic        issue_acc;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_full;
  logic [31:1] cnt_inc;
  logic [31:1] cnt_dec;

  assign wb_en     = reg_w_from_wb && (wr_back_addr != 5'd0);
  assign issue_req = issue_valid && issue_rd_w && (issue_rd_addr != 5'd0);
  assign issue_acc = issue_req && !hazard_stall;

  // A retire landing this cycle hides one pending write from the reader.
  function automatic logic src_busy(input logic [4:0] a);
    logic busy;
    busy = 1'b0;
    if (a != 5'd0) begin
      if (wb_en && (wr_back_addr == a))
        busy = (pcnt[a] > PCNT_W'(1));
      else
        busy = (pcnt[a] != '0);
    end
    return busy;
  endfunction

  function automatic logic [31:0] rd_port(input logic [4:0] a);
    logic [31:0] d;
    d = '0;
    if (a != 5'd0) begin
      if (wb_en && (wr_back_addr == a))
        d = wr_back_data;
      else
        d = regs[a];
    end
    return d;
  endfunction

  always_comb begin
    rs1_data     = rd_port(rs1_addr);
    rs2_data     = rd_port(rs2_addr);
    rs1_busy     = rs1_used && src_busy(rs1_addr);
    rs2_busy     = rs2_used && src_busy(rs2_addr);
    rd_full      = issue_req && (pcnt[issue_rd_addr] == PCNT_MAX);
    hazard_stall = rs1_busy || rs2_busy || rd_full;
  end

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_inc[i] = issue_acc && (issue_rd_addr == 5'(i));
      cnt_dec[i] = wb_en && (wr_back_addr == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
        pcnt[i] <= '0;
      end
    end else begin
      if (wb_en)
        regs[wr_back_addr] <= wr_back_data;
      for (int i = 1; i < 32; i++) begin
        if (flush)
          pcnt[i] <= '0;
        else if (cnt_inc[i] && !cnt_dec[i])
          pcnt[i] <= pcnt[i] + PCNT_W'(1);
        else if (!cnt_inc[i] && cnt_dec[i] && (pcnt[i] != '0))
          pcnt[i] <= pcnt[i] - PCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed and random stimulus against an array-based model of the register file and scoreboard.
module tb_reg_file;

  localparam int PCNT_W = 2;
  localparam int CMAX   = (1 << PCNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_w_from_wb;
  logic [4:0]  wr_back_addr;
  logic [31:0] wr_back_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_used;
  logic        rs2_used;
  logic        issue_valid;
  logic        issue_rd_w;
  logic [4:0]  issue_rd_addr;
  logic        flush;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        hazard_stall;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_stall;

  always #5 clk = ~clk;

  reg_file #(.PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst(rst),
    .reg_w_from_wb(reg_w_from_wb), .wr_back_addr(wr_back_addr), .wr_back_data(wr_back_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_valid(issue_valid), .issue_rd_w(issue_rd_w), .issue_rd_addr(issue_rd_addr),
    .flush(flush), .rs1_data(rs1_data), .rs2_data(rs2_data), .hazard_stall(hazard_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; reg_w_from_wb = 0; wr_back_addr = 0; wr_back_data = 0;
    rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    issue_valid = 0; issue_rd_w = 0; issue_rd_addr = 0; flush = 0;
  endtask

  function automatic bit retiring(input int a);
    return reg_w_from_wb && wr_back_addr != 0 && int'(wr_back_addr) == a;
  endfunction

  function automatic int eff_cnt(input int a);
    int c;
    c = m_cnt[a];
    if (retiring(a) && c > 0) c--;
    return c;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'h0;
    if (retiring(a)) return wr_back_data;
    return m_regs[a];
  endfunction

  // Compare all outputs against the model while inputs are stable.
  task automatic settle(input string tag);
    #1;
    m_stall = (rs1_used && rs1_addr != 0 && eff_cnt(int'(rs1_addr)) != 0) ||
              (rs2_used && rs2_addr != 0 && eff_cnt(int'(rs2_addr)) != 0) ||
              (issue_valid && issue_rd_w && issue_rd_addr != 0 && m_cnt[issue_rd_addr] == CMAX);
    chk({tag, ".rs1"}, rs1_data, m_read(int'(rs1_addr)));
    chk({tag, ".rs2"}, rs2_data, m_read(int'(rs2_addr)));
    chk({tag, ".stall"}, {31'h0, hazard_stall}, {31'h0, m_stall});
  endtask

  task automatic advance();
    bit acc;
    @(posedge clk);
    acc = issue_valid && issue_rd_w && issue_rd_addr != 0 && !m_stall;
    if (rst) begin
      for (int a = 0; a < 32; a++) begin m_regs[a] = 0; m_cnt[a] = 0; end
    end else begin
      if (reg_w_from_wb && wr_back_addr != 0) m_regs[wr_back_addr] = wr_back_data;
      for (int a = 1; a < 32; a++) begin
        bit inc, dec;
        inc = acc && int'(issue_rd_addr) == a;
        dec = retiring(a);
        if (flush) m_cnt[a] = 0;
        else if (inc && !dec) m_cnt[a]++;
        else if (dec && !inc && m_cnt[a] > 0) m_cnt[a]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    reg_w_from_wb = 1; wr_back_addr = a; wr_back_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1; issue_rd_w = 1; issue_rd_addr = a;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) begin m_regs[a] = 0; m_cnt[a] = 0; end
    m_stall = 0;
    idle();
    rst = 1;
    @(negedge clk);
    settle("rst_hold"); advance();
    idle(); rs1_addr = 5; rs2_addr = 7; rs1_used = 1; rs2_used = 1;
    settle("post_rst");
    chk("post_rst_rs1_zero", rs1_data, 32'h0);
    chk("post_rst_nostall", {31'h0, hazard_stall}, 32'h0);
    advance();

    // write then read
    idle(); wb(5, 32'hDEADBEEF); settle("wr5"); advance();
    idle(); rs1_addr = 5; settle("rd5");
    chk("read_x5", rs1_data, 32'hDEADBEEF); advance();

    // same-cycle bypass
    idle(); wb(7, 32'h12345678); rs2_addr = 7; settle("byp7");
    chk("bypass_x7", rs2_data, 32'h12345678); advance();

    // x0 is hardwired
    idle(); wb(0, 32'hFFFFFFFF); rs1_addr = 0; settle("wr0");
    chk("x0_bypass_zero", rs1_data, 32'h0); advance();
    idle(); rs1_addr = 0; settle("rd0");
    chk("x0_read_zero", rs1_data, 32'h0); advance();
    idle(); issue(0); settle("iss0");
    chk("x0_issue_nostall", {31'h0, hazard_stall}, 32'h0); advance();
    idle(); issue(0); rs1_used = 1; rs1_addr = 0; settle("iss0b");
    chk("x0_issue_again_nostall", {31'h0, hazard_stall}, 32'h0); advance();

    // scoreboard RAW hazard resolved by retire with bypass
    idle(); issue(3); settle("iss3"); advance();
    idle(); rs1_used = 1; rs1_addr = 3; settle("raw3");
    chk("raw_x3_stall", {31'h0, hazard_stall}, 32'h1); advance();
    idle(); rs1_used = 1; rs1_addr = 3; wb(3, 32'hA5A50003); settle("ret3");
    chk("ret_x3_nostall", {31'h0, hazard_stall}, 32'h0);
    chk("ret_x3_data", rs1_data, 32'hA5A50003); advance();
    idle(); rs1_used = 1; rs1_addr = 3; settle("clr3");
    chk("x3_clear", {31'h0, hazard_stall}, 32'h0); advance();

    // saturation at CMAX
    for (int k = 0; k < 3; k++) begin
      idle(); issue(9); settle("iss9");
      chk("iss9_accept", {31'h0, hazard_stall}, 32'h0); advance();
    end
    idle(); issue(9); settle("iss9_full");
    chk("iss9_full_stall", {31'h0, hazard_stall}, 32'h1); advance();
    for (int k = 0; k < 2; k++) begin
      idle(); wb(9, 32'h9 + k); settle("ret9"); advance();
    end
    idle(); rs1_used = 1; rs1_addr = 9; settle("cnt9_one");
    chk("cnt9_one_stall", {31'h0, hazard_stall}, 32'h1); advance();
    idle(); issue(9); wb(9, 32'h99); settle("iss_ret9");
    chk("iss_ret9_nostall", {31'h0, hazard_stall}, 32'h0); advance();
    idle(); rs1_used = 1; rs1_addr = 9; settle("cnt9_still_one");
    chk("cnt9_still_one_stall", {31'h0, hazard_stall}, 32'h1); advance();
    idle(); rs1_used = 1; rs1_addr = 9; wb(9, 32'h999); settle("cnt9_last");
    chk("cnt9_last_nostall", {31'h0, hazard_stall}, 32'h0); advance();

    // flush clears counters but not a concurrent write-back
    idle(); issue(4); settle("iss4a"); advance();
    idle(); issue(4); settle("iss4b"); advance();
    idle(); rs2_used = 1; rs2_addr = 4; settle("cnt4_two");
    chk("cnt4_two_stall", {31'h0, hazard_stall}, 32'h1); advance();
    idle(); flush = 1; issue(4); wb(10, 32'hF1F1F1F1); settle("flush"); advance();
    idle(); rs2_used = 1; rs2_addr = 4; rs1_addr = 10; settle("post_flush");
    chk("post_flush_nostall", {31'h0, hazard_stall}, 32'h0);
    chk("flush_wb_kept", rs1_data, 32'hF1F1F1F1); advance();

    // reset mid-sequence
    idle(); issue(6); settle("iss6"); advance();
    idle(); rst = 1; wb(11, 32'h11); issue(6); flush = 1; settle("rst_mid"); advance();
    idle(); rs1_used = 1; rs2_used = 1; rs1_addr = 5; rs2_addr = 6; settle("post_rst2");
    chk("rst_mid_rs1", rs1_data, 32'h0);
    chk("rst_mid_nostall", {31'h0, hazard_stall}, 32'h0); advance();
    idle(); rs1_addr = 11; settle("rst_mid_x11");
    chk("rst_mid_x11_zero", rs1_data, 32'h0); advance();

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      idle();
      rst           = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 39) == 0);
      reg_w_from_wb = $urandom_range(0, 1);
      wr_back_addr  = 5'($urandom_range(0, 7));
      wr_back_data  = $urandom;
      rs1_addr      = 5'($urandom_range(0, 7));
      rs2_addr      = 5'($urandom_range(0, 7));
      rs1_used      = $urandom_range(0, 1);
      rs2_used      = $urandom_range(0, 1);
      issue_valid   = $urandom_range(0, 1);
      issue_rd_w    = ($urandom_range(0, 3) != 0);
      issue_rd_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) issue_rd_addr = 5'($urandom_range(8, 31));
      settle("rand");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have one parameter: PCNT_W, default 2, width of each per-register pending-write counter (maximum count 2**PCNT_W-1).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- reg_w_from_wb  in  1  write-back enable from the WB stage.
- wr_back_addr  in  5  write-back destination register.
- wr_back_data  in  32  write-back data.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_used  in  1  decoded instruction reads rs1.
- rs2_used  in  1  decoded instruction reads rs2.
- issue_valid  in  1  decoded instruction leaves ID this cycle.
- issue_rd_w  in  1  issuing instruction writes a register.
- issue_rd_addr  in  5  issuing instruction's destination.
- flush  in  1  pipeline flush; discards all in-flight producers.
- rs1_data  out  32  read port 1 data.
- rs2_data  out  32  read port 2 data.
- hazard_stall  out  1  ID must hold; issue is blocked.

Function
REQ-003 The block SHALL hold 31 writable 32-bit registers x1..x31; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-004 A write SHALL occur at the rising edge when reg_w_from_wb=1 and wr_back_addr!=0.
REQ-005 Reads SHALL be combinational with write-first bypass: if reg_w_from_wb=1, wr_back_addr!=0 and wr_back_addr equals rsN_addr, rsN_data SHALL equal wr_back_data in the same cycle.
REQ-006 The block SHALL keep one PCNT_W-bit pending counter per register x1..x31; x0's count SHALL be constant 0.
REQ-007 Accepted issue: issue_valid=1, issue_rd_w=1, issue_rd_addr!=0 and hazard_stall=0.
REQ-008 Retire: reg_w_from_wb=1 and wr_back_addr!=0.
REQ-009 Per register at each edge:
- accepted issue only: count +1
- retire only: count -1, saturating at 0 (no underflow)
- both in the same cycle: count unchanged
REQ-010 Effective count SHALL be the stored count minus 1 when a retire to that register occurs this cycle, otherwise the stored count, floored at 0.
REQ-011 hazard_stall SHALL be 1 if any of these holds:
- rs1_used=1, rs1_addr!=0 and the effective count of rs1_addr is nonzero
- the same condition for rs2
- issue_valid=1, issue_rd_w=1, issue_rd_addr!=0 and the stored count of issue_rd_addr is at maximum
Otherwise hazard_stall SHALL be 0.
REQ-012 When hazard_stall=1, issue_valid SHALL have no effect on any counter.
REQ-013 When flush=1, all counters SHALL be 0 after the edge, overriding issue and retire. A write-back in the same cycle SHALL still update the register array.
REQ-014 hazard_stall SHALL be combinational; counter updates SHALL take effect one cycle after the qualifying inputs.

Reset
REQ-015 When rst=1 at a rising edge, all registers and all counters SHALL become 0. rst SHALL override write, issue and flush.
REQ-016 During reset and after it, with no write in flight: rs1_data=0, rs2_data=0, hazard_stall=0 (given a count of 0).

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Write then read: write x5=0xDEADBEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF.
- Bypass: in one cycle write x7=0x12345678 with rs2_addr=7 -> rs2_data=0x12345678 in that cycle.
- x0: write x0=0xFFFFFFFF -> rs1_addr=0 reads 0. Issue rd=0 -> no stall and no count change.
- Scoreboard: issue rd=x3; next cycle rs1_used=1, rs1_addr=3 -> hazard_stall=1. Retire x3 in that cycle -> hazard_stall=0 and rs1_data equals the retired data.
- Saturation: three accepted issues to x9 -> count=3; a fourth issue to x9 -> hazard_stall=1 and count stays 3. Simultaneous issue and retire to x9 at count 1 -> count stays 1.
- Flush and reset: count(x4)=2, then flush -> count 0 and no stall on x4. Assert rst mid-sequence -> all reads 0 and hazard_stall=0.
